// File: rtl/sr_input_conditioner_pkg.sv
// rtl/sr_input_conditioner_pkg.sv - shared types and width helpers for the SR input conditioner
package sr_cond_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SET_PULSE = 2'd1,
    RST_PULSE = 2'd2
  } state_t;

  localparam int CONFLICT_CNT_W = 8;
  localparam logic [CONFLICT_CNT_W-1:0] CONFLICT_CNT_MAX = '1;

  // Bits needed to hold 0..max_val, never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sr_input_conditioner_if.sv
// rtl/sr_input_conditioner_if.sv - raw request / conditioned pulse bundle (conflict_cnt_o with SR_CONFLICT_COUNT_EN)
interface sr_input_conditioner_if;

  logic set_raw;
  logic reset_raw;
  logic set_o;
  logic reset_o;
  logic q_o;
  logic conflict_o;
`ifdef SR_CONFLICT_COUNT_EN
  logic [sr_cond_pkg::CONFLICT_CNT_W-1:0] conflict_cnt_o;

  modport master (
    output set_raw, reset_raw,
    input  set_o, reset_o, q_o, conflict_o, conflict_cnt_o
  );
  modport slave (
    input  set_raw, reset_raw,
    output set_o, reset_o, q_o, conflict_o, conflict_cnt_o
  );
`else
  modport master (
    output set_raw, reset_raw,
    input  set_o, reset_o, q_o, conflict_o
  );
  modport slave (
    input  set_raw, reset_raw,
    output set_o, reset_o, q_o, conflict_o
  );
`endif

endinterface

// File: rtl/sr_input_conditioner_debounce.sv
// rtl/sr_input_conditioner_debounce.sv - one channel: synchroniser, debounce counter, rising-edge strobe
module sr_debounce
  import sr_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // The strobe is registered on the same edge the level flips, so it
  // is high exactly in the first cycle the new level is visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt    <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      rise   <= 1'b0;
      if (synced == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= synced;
        rise  <= synced;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_input_conditioner.sv
// rtl/sr_input_conditioner.sv - debounced, mutually exclusive set/reset pulses for an SR latch (SR_CONFLICT_COUNT_EN adds a conflict counter)
module sr_input_conditioner
  import sr_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_CYCLES    = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  sr_input_conditioner_if.slave bus
);

  localparam int PULSE_W = cnt_width(PULSE_CYCLES - 1);
  localparam logic [PULSE_W-1:0] PULSE_LOAD = PULSE_W'(PULSE_CYCLES - 1);

  logic               deb_set;
  logic               deb_rst;
  logic               req_set;
  logic               req_rst;
  logic               drop;
  state_t             state;
  logic [PULSE_W-1:0] pulse_cnt;
  logic               set_q;
  logic               reset_q;
  logic               q_q;
  logic               conflict_q;

  sr_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_set_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (bus.set_raw),
    .level (deb_set),
    .rise  (req_set)
  );

  sr_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_rst_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (bus.reset_raw),
    .level (deb_rst),
    .rise  (req_rst)
  );

  // A request is only honoured from IDLE with the opposite channel released.
  always_comb begin
    drop = 1'b0;
    if (state == IDLE) begin
      drop = (req_set && req_rst) || (req_set && deb_rst) || (req_rst && deb_set);
    end else begin
      drop = req_set || req_rst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pulse_cnt  <= '0;
      set_q      <= 1'b0;
      reset_q    <= 1'b0;
      q_q        <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= drop || (deb_set && deb_rst);
      case (state)
        IDLE: begin
          if (req_set && !drop) begin
            state     <= SET_PULSE;
            set_q     <= 1'b1;
            q_q       <= 1'b1;
            pulse_cnt <= PULSE_LOAD;
          end else if (req_rst && !drop) begin
            state     <= RST_PULSE;
            reset_q   <= 1'b1;
            q_q       <= 1'b0;
            pulse_cnt <= PULSE_LOAD;
          end
        end
        SET_PULSE, RST_PULSE: begin
          if (pulse_cnt == '0) begin
            state   <= IDLE;
            set_q   <= 1'b0;
            reset_q <= 1'b0;
          end else begin
            pulse_cnt <= pulse_cnt - 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          set_q   <= 1'b0;
          reset_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.set_o      = set_q;
  assign bus.reset_o    = reset_q;
  assign bus.q_o        = q_q;
  assign bus.conflict_o = conflict_q;

`ifdef SR_CONFLICT_COUNT_EN
  logic [CONFLICT_CNT_W-1:0] conflict_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (conflict_q && conflict_cnt != CONFLICT_CNT_MAX) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

  assign bus.conflict_cnt_o = conflict_cnt;
`endif

endmodule

// File: tb/tb_sr_input_conditioner.sv
// tb/tb_sr_input_conditioner.sv - directed self-checking bench for sr_input_conditioner
module tb_sr_input_conditioner;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  sr_input_conditioner_if bus ();

  sr_input_conditioner #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .PULSE_CYCLES    (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    logic [3:0] outs;
    rst_n = 1'b0;
    bus.set_raw = 1'b0;
    bus.reset_raw = 1'b0;
    ticks(3);
    outs = {bus.set_o, bus.reset_o, bus.q_o, bus.conflict_o};
    checks++;
    if (outs !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0000", outs);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      outs = {bus.set_o, bus.reset_o, bus.q_o, bus.conflict_o};
      checks++;
      if (outs !== 4'b0000) begin
        failures++;
        $display("FAIL idle_after_release edge=%0d got=%b want=0000", i, outs);
      end
    end
  endtask

  task automatic test_clean_set();
    logic exp_set;
    bus.set_raw = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_set = (i == 7) || (i == 8);
      checks++;
      if (bus.set_o !== exp_set) begin
        failures++;
        $display("FAIL clean_set_o edge=%0d got=%b want=%b", i, bus.set_o, exp_set);
      end
      checks++;
      if (bus.q_o !== (i >= 7)) begin
        failures++;
        $display("FAIL clean_q_o edge=%0d got=%b want=%b", i, bus.q_o, (i >= 7));
      end
      checks++;
      if (bus.reset_o !== 1'b0) begin
        failures++;
        $display("FAIL clean_reset_o edge=%0d got=%b want=0", i, bus.reset_o);
      end
    end
    for (int i = 1; i <= 50; i++) begin
      tick();
      checks++;
      if (bus.set_o !== 1'b0) begin
        failures++;
        $display("FAIL hold_no_repeat cycle=%0d got=%b want=0", i, bus.set_o);
      end
    end
    bus.set_raw = 1'b0;
    ticks(10);
  endtask

  task automatic test_bounce();
    logic exp_set;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) bus.set_raw = ((i / 2) % 2 == 0);
      tick();
      checks++;
      if (bus.set_o !== 1'b0) begin
        failures++;
        $display("FAIL bounce_set_o cycle=%0d got=%b want=0", i, bus.set_o);
      end
    end
    bus.set_raw = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_set = (i == 7) || (i == 8);
      checks++;
      if (bus.set_o !== exp_set) begin
        failures++;
        $display("FAIL settled_set_o edge=%0d got=%b want=%b", i, bus.set_o, exp_set);
      end
    end
    bus.set_raw = 1'b0;
    ticks(10);
  endtask

  task automatic test_conflict();
    int seen;
    seen = 0;
    bus.set_raw = 1'b1;
    bus.reset_raw = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (bus.conflict_o === 1'b1) seen++;
      checks++;
      if ({bus.set_o, bus.reset_o} !== 2'b00) begin
        failures++;
        $display("FAIL conflict_pulses edge=%0d got=%b want=00", i, {bus.set_o, bus.reset_o});
      end
      checks++;
      if (bus.conflict_o !== (i >= 7)) begin
        failures++;
        $display("FAIL conflict_o edge=%0d got=%b want=%b", i, bus.conflict_o, (i >= 7));
      end
      checks++;
      if (bus.q_o !== 1'b1) begin
        failures++;
        $display("FAIL conflict_q_o edge=%0d got=%b want=1", i, bus.q_o);
      end
    end
    bus.set_raw = 1'b0;
    bus.reset_raw = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (bus.conflict_o === 1'b1) seen++;
    end
    checks++;
    if (bus.conflict_o !== 1'b0) begin
      failures++;
      $display("FAIL conflict_clears got=%b want=0", bus.conflict_o);
    end
    checks++;
    if (seen != 12) begin
      failures++;
      $display("FAIL conflict_cycle_count got=%0d want=12", seen);
    end
`ifdef SR_CONFLICT_COUNT_EN
    checks++;
    if (bus.conflict_cnt_o !== 8'(seen)) begin
      failures++;
      $display("FAIL conflict_cnt_o got=%0d want=%0d", bus.conflict_cnt_o, seen);
    end
`endif
  endtask

  task automatic test_blocked();
    logic exp_rst;
    bus.set_raw = 1'b1;
    ticks(10);
    bus.reset_raw = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++;
      if (bus.reset_o !== 1'b0) begin
        failures++;
        $display("FAIL blocked_reset_o edge=%0d got=%b want=0", i, bus.reset_o);
      end
      checks++;
      if (bus.conflict_o !== (i >= 7)) begin
        failures++;
        $display("FAIL blocked_conflict edge=%0d got=%b want=%b", i, bus.conflict_o, (i >= 7));
      end
    end
    bus.set_raw = 1'b0;
    bus.reset_raw = 1'b0;
    ticks(10);
    bus.reset_raw = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_rst = (i == 7) || (i == 8);
      checks++;
      if (bus.reset_o !== exp_rst) begin
        failures++;
        $display("FAIL repress_reset_o edge=%0d got=%b want=%b", i, bus.reset_o, exp_rst);
      end
      checks++;
      if (bus.q_o !== (i < 7)) begin
        failures++;
        $display("FAIL repress_q_o edge=%0d got=%b want=%b", i, bus.q_o, (i < 7));
      end
      checks++;
      if (bus.set_o !== 1'b0) begin
        failures++;
        $display("FAIL repress_set_o edge=%0d got=%b want=0", i, bus.set_o);
      end
    end
    bus.reset_raw = 1'b0;
    ticks(10);
  endtask

  task automatic test_reset_mid_pulse();
    logic exp_set;
    bus.set_raw = 1'b1;
    ticks(7);
    checks++;
    if (bus.set_o !== 1'b1) begin
      failures++;
      $display("FAIL mid_pulse_precond got=%b want=1", bus.set_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.set_o, bus.q_o} !== 2'b00) begin
      failures++;
      $display("FAIL async_reset_drop got=%b want=00", {bus.set_o, bus.q_o});
    end
    ticks(2);
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_set = (i == 7) || (i == 8);
      checks++;
      if (bus.set_o !== exp_set) begin
        failures++;
        $display("FAIL post_reset_set_o edge=%0d got=%b want=%b", i, bus.set_o, exp_set);
      end
    end
    bus.set_raw = 1'b0;
    ticks(10);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.set_raw = 1'b0;
    bus.reset_raw = 1'b0;
    #1;
    test_reset();
    test_clean_set();
    test_bounce();
    test_conflict();
    test_blocked();
    test_reset_mid_pulse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_input_conditioner.md
Name: sr_input_conditioner

Overview:
Front-end stage that drives the set/reset inputs of the SR latch from raw, asynchronous, bouncing switch/button signals. It does the following:
- synchronises each raw input;
- debounces it;
- turns each debounced rising edge into a clean fixed-width pulse;
- guarantees set and reset pulses are never asserted together, so the latch never sees the forbidden state.

It also keeps a shadow copy of the latch state for observation.

Parameters:
SYNC_STAGES, 2, synchroniser flop depth per raw input (>=2)
DEBOUNCE_CYCLES, 16, consecutive stable cycles required before the debounced level changes (>=1)
PULSE_CYCLES, 1, width in clocks of each set_o/reset_o pulse (>=1)

Ports:
clk  input  1  single clock
rst_n  input  1  asynchronous active-low reset
set_raw  input  1  raw asynchronous set request (button/switch)
reset_raw  input  1  raw asynchronous reset request
set_o  output  1  conditioned set pulse to latch
reset_o  output  1  conditioned reset pulse to latch
q_o  output  1  shadow of latch state (1 after set pulse, 0 after reset pulse)
conflict_o  output  1  high on any cycle a request is suppressed or both debounced levels are high

Behaviour:
- Single clock domain on clk. Reset is asynchronous and active-low (rst_n); assertion takes effect immediately, release is sampled on clk.
- In reset: all synchroniser flops, debounced levels, debounce counters and the pulse counter are 0; state is IDLE; set_o, reset_o, q_o and conflict_o are all 0.
- Synchroniser: SYNC_STAGES-deep flop chain per raw input; sync output = last stage.
- Debounce, per channel:
  - The counter increments each cycle the sync output differs from the debounced level.
  - The counter clears to 0 on any cycle they are equal, so bounce restarts the count.
  - When the counter would reach DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- Edge detect: req_set/req_rst is a one-cycle strobe on a 0->1 transition of the debounced level. Falling edges produce nothing.
- FSM states: IDLE, SET_PULSE, RST_PULSE.
  - IDLE, req_set only, debounced reset low -> SET_PULSE; q_o<=1; pulse counter loads PULSE_CYCLES-1.
  - IDLE, req_rst only, debounced set low -> RST_PULSE; q_o<=0; pulse counter loads PULSE_CYCLES-1.
  - IDLE, req_set and req_rst in the same cycle -> stay IDLE; both dropped; conflict_o=1 that cycle.
  - IDLE, request arrives while the other channel's debounced level is high -> dropped; conflict_o=1.
  - SET_PULSE/RST_PULSE: set_o/reset_o high (registered from state). Pulse counter decrements; at 0, return to IDLE next cycle.
  - Any request arriving while in a pulse state is dropped (not queued); conflict_o=1 that cycle.
- conflict_o is also 1 on every cycle both debounced levels are high.
- Invariant: set_o & reset_o is never 1.
- Latency: raw level held stable from edge 0 -> pulse output high after edge SYNC_STAGES+DEBOUNCE_CYCLES+1. Example: defaults give edge 19; SYNC_STAGES=2, DEBOUNCE_CYCLES=4 gives edge 7.
- Repeat pulse: the same channel pulses again only after its debounced level falls and rises again. Holding a button does not repeat.
- Reset mid-pulse: output drops immediately. If the raw input is still high after release, a fresh full debounce occurs, then a new pulse.

Optional Feature:
SR_CONFLICT_COUNT_EN
- Defined: adds output conflict_cnt_o [7:0].
  - Counts cycles with conflict_o=1, at most +1 per cycle.
  - Saturates at 255.
  - Cleared only by rst_n.
- Undefined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Package sr_cond_pkg:
  - state typedef enum (IDLE, SET_PULSE, RST_PULSE);
  - conflict counter width constant (8);
  - counter-width helper constants.
- Sub-module sr_debounce: synchroniser, debounce counter and rising-edge strobe for one channel, parameterised by SYNC_STAGES and DEBOUNCE_CYCLES. Instantiated twice.
- FSM, q_o and conflict logic live in the top.

Test Plan:
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, PULSE_CYCLES=2.
- Reset values: rst_n=0 for 3 cycles -> all outputs 0. Release with raws low -> outputs stay 0 for 20 cycles.
- Clean set: set_raw 0->1 held -> set_o high at edges 7 and 8 only. q_o=1 from edge 7. Holding for 50 cycles gives no further pulse.
- Bounce reject: set_raw toggles every 2 cycles for 20 cycles -> no set_o. After it settles high, pulse follows 7 edges later.
- Conflict: set_raw and reset_raw rise in the same cycle -> no pulses. conflict_o=1 from edge 7 while both held. q_o unchanged.
- Blocked request: set held high, then reset_raw rises -> reset_o never asserts; conflict_o high. Release set, re-press reset -> reset_o 2-cycle pulse; q_o=0.
- Reset mid-pulse: rst_n low during set_o -> set_o=0 immediately. With set_raw still high, the next set_o comes 7 edges after release. With SR_CONFLICT_COUNT_EN, the conflict scenario's count matches the number of conflict_o cycles.
